// File: rtl/audio_pkg.sv
// Shared sample types for the audio transmit path: one signed channel sample
// and a packed left/right stereo pair.
package audio_pkg;

  localparam int DATA_WIDTH = 24;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO of stereo pairs; extended pointers give full/empty
// and the occupancy count without a separate counter.
module sample_fifo
  import audio_pkg::*;
#(
  parameter type T    = stereo_t,
  parameter int  LOGD = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic          full,
  output logic          empty,
  output logic [LOGD:0] count
);

  localparam int DEPTH = 1 << LOGD;

  T              r_mem [DEPTH];
  logic [LOGD:0] r_wr_ptr;
  logic [LOGD:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: a cleared pointer pair already makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[LOGD-1:0]] <= push_data;
  end

  assign count    = r_wr_ptr - r_rd_ptr;
  assign full     = (count == (LOGD+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = r_mem[r_rd_ptr[LOGD-1:0]];

endmodule

// File: rtl/audio_dac_tx.sv
// I2S master transmitter: buffers stereo pairs and shifts them out MSB-first,
// one BCLK after each LRCK edge, with a zero frame and underrun pulse when starved.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int LOGD      = 3,
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  output logic [LOGD:0]         fifo_count,
  output logic                  underrun,
  output logic                  aud_bclk,
  output logic                  aud_daclrck,
  output logic                  aud_dacdat
);

  localparam int DEPTH      = 1 << LOGD;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_bclk;
  logic             r_lrck;
  logic             r_dat;
  logic             r_underrun;
  logic             r_write_ready;
  sample_t          r_shift_l;
  sample_t          r_shift_r;

  logic             w_tick;
  logic             w_fall;
  logic             w_wrap;
  logic             w_right;
  logic             w_data_slot;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [BIT_W-1:0] w_bit_next;
  logic [BIT_W-1:0] w_pos;
  logic [LOGD:0]    w_count;
  logic [LOGD:0]    w_count_next;
  stereo_t          w_push_data;
  stereo_t          w_pop_data;

  assign w_tick      = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fall      = w_tick && r_bclk;
  assign w_wrap      = (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_bit_next  = w_wrap ? '0 : r_bit_cnt + 1'b1;
  assign w_right     = (w_bit_next >= BIT_W'(SLOT_BITS));
  assign w_pos       = w_right ? w_bit_next - BIT_W'(SLOT_BITS) : w_bit_next;
  assign w_data_slot = (w_pos != '0) && (w_pos <= BIT_W'(DATA_WIDTH));

  assign w_push       = write && r_write_ready && !w_full;
  assign w_pop        = w_fall && w_wrap && !w_empty;
  assign w_push_data  = {writedata_left, writedata_right};
  assign w_count_next = w_count + (LOGD+1)'(w_push) - (LOGD+1)'(w_pop);

  sample_fifo #(
    .T    (stereo_t),
    .LOGD (LOGD)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Ready looks at the post-edge occupancy so the pair that fills the FIFO closes the door at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_write_ready <= 1'b0;
    else        r_write_ready <= (w_count_next < (LOGD+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // LRCK and data move on the BCLK falling edge so the codec can sample on the rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= '0;
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_underrun <= 1'b0;
      r_shift_l  <= '0;
      r_shift_r  <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrck    <= w_right;
        r_dat     <= 1'b0;
        if (w_wrap) begin
          if (w_empty) begin
            r_shift_l  <= '0;
            r_shift_r  <= '0;
            r_underrun <= 1'b1;
          end else begin
            r_shift_l <= w_pop_data.left;
            r_shift_r <= w_pop_data.right;
          end
        end else if (w_data_slot) begin
          if (w_right) begin
            r_dat     <= r_shift_r[DATA_WIDTH-1];
            r_shift_r <= {r_shift_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            r_dat     <= r_shift_l[DATA_WIDTH-1];
            r_shift_l <= {r_shift_l[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign write_ready = r_write_ready;
  assign fifo_count  = w_count;
  assign underrun    = r_underrun;
  assign aud_bclk    = r_bclk;
  assign aud_daclrck = r_lrck;
  assign aud_dacdat  = r_dat;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: a timing model predicts frame loads and FIFO state,
// and an I2S receiver decodes each frame against a scoreboard of expected pairs.
module tb_audio_dac_tx;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        write = 1'b0;
  logic [23:0] wl    = '0;
  logic [23:0] wr    = '0;
  logic        write_ready;
  logic [3:0]  fifo_count;
  logic        underrun;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  audio_dac_tx dut (
    .clk             (clk),
    .reset           (reset),
    .write           (write),
    .writedata_left  (wl),
    .writedata_right (wr),
    .write_ready     (write_ready),
    .fifo_count      (fifo_count),
    .underrun        (underrun),
    .aud_bclk        (aud_bclk),
    .aud_daclrck     (aud_daclrck),
    .aud_dacdat      (aud_dacdat)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        expReady;
    logic [3:0]  expCount;
  } fillVec_t;

  fillVec_t fillTab[9];

  // Timing model state: clk edges since reset release, buffered pairs, expected frames.
  int          edgeN  = 0;
  logic [47:0] mq[$];
  logic [47:0] sb[$];
  logic        mReady = 1'b0;
  logic        mUnder = 1'b0;
  logic        mBclk  = 1'b0;

  int          riseIdx    = 0;
  int          framesDone = 0;
  logic [63:0] frameBits  = '0;
  logic [63:0] lrBits     = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatch++;
    $display("[TB] FAIL %s: event not seen at t=%0t", name, $time);
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    write = 1'b1;
    wl    = l;
    wr    = r;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic waitFramePos(input int pos);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edgeN % 1024) != pos && n < 2100);
    if ((edgeN % 1024) != pos) failNow("wait_frame_pos");
  endtask

  function automatic logic [63:0] expFrame(input logic [47:0] pair);
    return {1'b0, pair[47:24], 7'b0, 1'b0, pair[23:0], 7'b0};
  endfunction

  // Frame loads fall on every 1024th clk edge (64 BCLK periods of 16 clks); a load sees the FIFO before that edge's push.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      edgeN  = 0;
      mReady = 1'b0;
      mUnder = 1'b0;
      mBclk  = 1'b0;
      mq.delete();
      sb.delete();
      sb.push_back('0);
    end else begin
      edgeN++;
      mUnder = 1'b0;
      if (edgeN % 8 == 0) mBclk = ~mBclk;
      if (edgeN % 1024 == 0) begin
        if (mq.size() > 0) sb.push_back(mq.pop_front());
        else begin
          sb.push_back('0);
          mUnder = 1'b1;
        end
      end
      if (write && mReady) mq.push_back({wl, wr});
      mReady = (mq.size() < 8);
    end
  end

  always @(negedge clk) begin
    checkOutput("cycle_rdy_cnt_und_bclk", {write_ready, fifo_count, underrun, aud_bclk},
                {mReady, 4'(mq.size()), mUnder, mBclk});
  end

  // I2S receiver: the k-th BCLK rise after reset carries frame bit (k-1) mod 64.
  initial forever begin
    @(posedge aud_bclk or negedge reset);
    if (!reset) begin
      riseIdx    = 0;
      framesDone = 0;
      frameBits  = '0;
      lrBits     = '0;
    end else begin
      int b;
      b = riseIdx % 64;
      frameBits[63-b] = aud_dacdat;
      lrBits[63-b]    = aud_daclrck;
      riseIdx++;
      if (b == 63) begin
        framesDone++;
        if (sb.size() == 0) failNow("frame_scoreboard");
        else begin
          logic [47:0] exp;
          exp = sb.pop_front();
          checkOutput("frame_data", frameBits, expFrame(exp));
        end
        checkOutput("frame_lrck", lrBits, 64'h00000000FFFFFFFF);
      end
    end
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      fillTab[i].l        = 24'h0A0000 + 24'(i * 24'h010101);
      fillTab[i].r        = 24'hF00000 + 24'(i * 24'h000111);
      fillTab[i].expReady = (i < 7);
      fillTab[i].expCount = (i < 8) ? 4'(i + 1) : 4'd8;
    end

    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_outputs",
                  {58'b0, write_ready, fifo_count, underrun, aud_bclk, aud_daclrck, aud_dacdat}, 64'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", write_ready, 1);

    $display("[TB] single pair");
    waitFramePos(20);
    applyStimulus(24'h800001, 24'h123456);

    $display("[TB] fill to full");
    waitFramePos(1023);
    waitFramePos(5);
    for (int i = 0; i < 9; i++) begin
      write = 1'b1;
      wl    = fillTab[i].l;
      wr    = fillTab[i].r;
      @(negedge clk);
      checkOutput("fill_ready", write_ready, fillTab[i].expReady);
      checkOutput("fill_count", fifo_count, fillTab[i].expCount);
    end
    write = 1'b0;

    $display("[TB] drain and underrun");
    repeat (9) waitFramePos(1023);
    @(negedge clk);
    checkOutput("underrun_on_empty", {underrun, fifo_count}, {1'b1, 4'd0});
    @(negedge clk);
    checkOutput("underrun_width", underrun, 0);
    waitFramePos(50);
    applyStimulus(24'h7FFFFF, 24'h000001);

    $display("[TB] push on load clk");
    waitFramePos(10);
    waitFramePos(1023);
    applyStimulus(24'hC3A55A, 24'h5A5AC3);
    checkOutput("push_on_load_empty", {underrun, fifo_count}, {1'b1, 4'd1});
    waitFramePos(1023);
    waitFramePos(100);
    applyStimulus(24'h111111, 24'h222222);
    applyStimulus(24'h333333, 24'h444444);
    applyStimulus(24'h555555, 24'h666666);
    waitFramePos(1023);
    applyStimulus(24'h777777, 24'h888888);
    checkOutput("push_on_load_cnt3", {underrun, fifo_count}, {1'b0, 4'd3});
    waitFramePos(5);
    applyStimulus(24'h999999, 24'hAAAAAA);
    checkOutput("count_four", fifo_count, 4);

    $display("[TB] reset mid-frame");
    waitFramePos(682);
    checkOutput("pre_rst_bclk_lrck", {aud_bclk, aud_daclrck}, 2'b11);
    #2 reset = 1'b0;
    #1 checkOutput("async_rst_clear",
                   {58'b0, write_ready, fifo_count, underrun, aud_bclk, aud_daclrck, aud_dacdat}, 64'h0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (1030) @(negedge clk);
    checkOutput("post_rst_frames", framesDone, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
